// File: rtl/term_pkg.sv
// term_pkg: shared geometry defaults, control codes and FSM states for the terminal writer.
package term_pkg;
    localparam int COLS_DEF = 60;
    localparam int ROWS_DEF = 17;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] SPACE = 8'h20;
    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_WRITE, S_RD, S_WT, S_WR, S_CLRROW
    } state_t;
    function automatic logic printable(input logic [7:0] c);
        return c >= 8'h20 && c != 8'h7F;
    endfunction
endpackage

// File: rtl/term_sweep.sv
// term_sweep: row-major cell counter from (0,start_row) to (COLS-1,end_row).
module term_sweep #(
    parameter int COLS = 60
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       start,
    input  logic       step,
    input  logic [4:0] start_row,
    input  logic [4:0] end_row,
    output logic [5:0] x,
    output logic [4:0] y,
    output logic       done
);
    localparam logic [5:0] XMAX = 6'(COLS - 1);
    assign done = x == XMAX && y == end_row;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x <= '0;
            y <= '0;
        end else if (start) begin
            x <= '0;
            y <= start_row;
        end else if (step) begin
            x <= x == XMAX ? 6'd0 : x + 6'd1;
            y <= x == XMAX ? y + 5'd1 : y;
        end
    end
endmodule

// File: rtl/term_writer.sv
// term_writer: byte-stream terminal front end driving the text VRAM upper port.
module term_writer
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_vram_din,
    input  logic [7:0]  i_vram_dout,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    output logic [5:0]  o_cur_x,
    output logic [4:0]  o_cur_y
);
    localparam logic [5:0] XMAX = 6'(COLS - 1);
    localparam logic [4:0] YMAX = 5'(ROWS - 1);
    state_t      state, state_nx;
    logic        live;
    logic [5:0]  cur_x, cur_x_nx, sx;
    logic [4:0]  cur_y, cur_y_nx, sy, sw_row;
    logic [10:0] waddr, waddr_nx;
    logic [7:0]  wdata, wdata_nx, rdata;
    logic        sw_start, sw_step, sw_done;
    assign o_cur_x = cur_x;
    assign o_cur_y = cur_y;
    // live stays low for the cycle after a reset edge so the VRAM port is quiet
    term_sweep #(.COLS(COLS)) u_sweep (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .start(sw_start), .step(sw_step),
        .start_row(sw_row), .end_row(YMAX), .x(sx), .y(sy), .done(sw_done)
    );
    always_comb begin
        state_nx    = state;
        cur_x_nx    = cur_x;
        cur_y_nx    = cur_y;
        waddr_nx    = waddr;
        wdata_nx    = wdata;
        sw_start    = 1'b0;
        sw_step     = 1'b0;
        sw_row      = 5'd0;
        o_ready     = 1'b0;
        o_vram_ce   = 1'b0;
        o_vram_wre  = 1'b0;
        o_vram_addr = {sy, sx};
        o_vram_din  = 8'h00;
        case (state)
            S_CLEAR: begin
                o_vram_ce  = live;
                o_vram_wre = live;
                o_vram_din = live ? SPACE : 8'h00;
                sw_step    = live;
                state_nx   = live && sw_done ? S_IDLE : S_CLEAR;
            end
            S_IDLE: begin
                o_ready     = 1'b1;
                o_vram_addr = {cur_y, cur_x};
                if (i_valid) begin
                    if (printable(i_data)) begin
                        state_nx = S_WRITE;
                        waddr_nx = {cur_y, cur_x};
                        wdata_nx = i_data;
                        cur_x_nx = cur_x == XMAX ? 6'd0 : cur_x + 6'd1;
                        cur_y_nx = cur_x == XMAX && cur_y != YMAX ? cur_y + 5'd1 : cur_y;
                    end else if (i_data == BS) begin
                        if (cur_x != 6'd0) begin
                            state_nx = S_WRITE;
                            cur_x_nx = cur_x - 6'd1;
                            waddr_nx = {cur_y, cur_x - 6'd1};
                            wdata_nx = SPACE;
                        end
                    end else if (i_data == FF) begin
                        state_nx = S_CLEAR;
                        cur_x_nx = 6'd0;
                        cur_y_nx = 5'd0;
                        sw_start = 1'b1;
                    end else if (i_data == CR) begin
                        cur_x_nx = 6'd0;
                    end else if (i_data == LF) begin
                        cur_y_nx = cur_y != YMAX ? cur_y + 5'd1 : cur_y;
                        state_nx = cur_y != YMAX ? S_IDLE : S_RD;
                        sw_start = cur_y == YMAX;
                        sw_row   = 5'd1;
                    end
                end
            end
            S_WRITE: begin
                o_vram_ce   = 1'b1;
                o_vram_wre  = 1'b1;
                o_vram_addr = waddr;
                o_vram_din  = wdata;
                // only a printable at the bottom-right cell can wrap into a scroll
                state_nx    = waddr == {YMAX, XMAX} ? S_RD : S_IDLE;
                sw_start    = waddr == {YMAX, XMAX};
                sw_row      = 5'd1;
            end
            S_RD: begin
                o_vram_ce = 1'b1;
                state_nx  = S_WT;
            end
            S_WT: state_nx = S_WR;
            S_WR: begin
                o_vram_ce   = 1'b1;
                o_vram_wre  = 1'b1;
                o_vram_addr = {sy - 5'd1, sx};
                o_vram_din  = rdata;
                state_nx    = sw_done ? S_CLRROW : S_RD;
                sw_start    = sw_done;
                sw_step     = !sw_done;
                sw_row      = YMAX;
            end
            S_CLRROW: begin
                o_vram_ce  = 1'b1;
                o_vram_wre = 1'b1;
                o_vram_din = SPACE;
                sw_step    = 1'b1;
                state_nx   = sw_done ? S_IDLE : S_CLRROW;
            end
            default: state_nx = S_CLEAR;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_CLEAR;
            live  <= 1'b0;
            cur_x <= '0;
            cur_y <= '0;
            waddr <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            cur_x <= cur_x_nx;
            cur_y <= cur_y_nx;
            waddr <= waddr_nx;
            wdata <= wdata_nx;
            rdata <= state == S_WT ? i_vram_dout : rdata;
        end
    end
endmodule

// File: tb/tb_term_writer.sv
// tb_term_writer: random byte stream against a screen-level model with a VRAM behavioural model.
module tb_term_writer;
    localparam int COLS = 60;
    localparam int ROWS = 17;
    logic        clk = 1'b0;
    logic        rst_n, i_valid, o_ready, o_vram_ce, o_vram_wre, wipe;
    logic [7:0]  i_data, o_vram_din, vram_dout;
    logic [10:0] o_vram_addr;
    logic [5:0]  o_cur_x;
    logic [4:0]  o_cur_y;
    logic [7:0]  vram [2048];
    logic [7:0]  scr [ROWS][COLS];
    int          mx, my;
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    term_writer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_vram_addr(o_vram_addr), .o_vram_din(o_vram_din), .i_vram_dout(vram_dout),
        .o_vram_ce(o_vram_ce), .o_vram_wre(o_vram_wre), .o_cur_x(o_cur_x), .o_cur_y(o_cur_y)
    );
    always @(posedge clk) begin
        if (wipe) begin
            for (int a = 0; a < 2048; a++) vram[a] <= 8'hEE;
        end else if (o_vram_ce) begin
            if (o_vram_wre) vram[o_vram_addr] <= o_vram_din;
            else vram_dout <= vram[o_vram_addr];
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask
    // idle cycles must show the model cursor; every write must land in the visible area
    always @(posedge clk) begin
        #3;
        if (rst_n && o_ready) begin
            chk("idle_ce", o_vram_ce, 0);
            chk("idle_cur_x", o_cur_x, mx);
            chk("idle_cur_y", o_cur_y, my);
            chk("idle_addr", o_vram_addr, my * 64 + mx);
        end
        if (rst_n && o_vram_ce && o_vram_wre)
            chk("in_area", o_vram_addr[5:0] < 6'd60 && o_vram_addr[10:6] < 5'd17, 1);
    end
    task automatic blank();
        for (int y = 0; y < ROWS; y++) for (int x = 0; x < COLS; x++) scr[y][x] = 8'h20;
    endtask
    task automatic newline(inout int eb);
        if (my < ROWS - 1) my++;
        else begin
            for (int y = 0; y < ROWS - 1; y++) for (int x = 0; x < COLS; x++) scr[y][x] = scr[y+1][x];
            for (int x = 0; x < COLS; x++) scr[ROWS-1][x] = 8'h20;
            eb += 3 * COLS * (ROWS - 1) + COLS;
        end
    endtask
    task automatic model(input logic [7:0] b, output logic ew, output int ea, output int ed, output int eb);
        ew = 0; ea = 0; ed = 0; eb = 0;
        if (b >= 8'h20 && b != 8'h7F) begin
            ew = 1; ea = my * 64 + mx; ed = b; eb = 1;
            scr[my][mx] = b;
            mx++;
            if (mx == COLS) begin
                mx = 0;
                newline(eb);
            end
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                ew = 1; ea = my * 64 + mx; ed = 8'h20; eb = 1;
                scr[my][mx] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            blank();
            mx = 0; my = 0; eb = COLS * ROWS;
        end else if (b == 8'h0A) newline(eb);
        else if (b == 8'h0D) mx = 0;
    endtask
    task automatic check_screen();
        int e = 0;
        logic [7:0] want;
        for (int a = 0; a < 2048; a++) begin
            want = (a[5:0] < 60 && a[10:6] < 17) ? scr[a[10:6]][a[5:0]] : 8'hEE;
            if (vram[a] !== want) e++;
        end
        chk("screen_bad_cells", e, 0);
    endtask
    task automatic check_clear();
        int e = 0;
        for (int i = 0; i < COLS * ROWS; i++) begin
            @(negedge clk);
            if (!(o_vram_ce === 1'b1 && o_vram_wre === 1'b1 && o_vram_din === 8'h20 && o_ready === 1'b0
                  && o_vram_addr === 11'((i / COLS) * 64 + i % COLS))) e++;
        end
        chk("clear_sweep_bad_cycles", e, 0);
        @(negedge clk);
        chk("clear_ready", o_ready, 1);
        chk("clear_addr", o_vram_addr, 0);
    endtask
    task automatic send(input logic [7:0] b, output int busy, output int wa, output int wd);
        int n = 0, ea, ed, eb;
        logic ew;
        busy = 0; wa = 0; wd = 0;
        while (!o_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            $display("FAIL ready_timeout: got 0 want 1");
            $fatal(1, "ready never returned");
        end
        model(b, ew, ea, ed, eb);
        i_data = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_data = 8'($urandom);
        wa = o_vram_addr;
        wd = o_vram_din;
        if (ew) begin
            chk("wr_strobe", o_vram_ce & o_vram_wre, 1);
            chk("wr_addr", o_vram_addr, ea);
            chk("wr_din", o_vram_din, ed);
        end
        while (!o_ready && busy < 4000) begin
            busy++;
            @(negedge clk);
        end
        chk("busy_cycles", busy, eb);
        check_screen();
    endtask
    function automatic logic [7:0] rnd_byte();
        int r = $urandom_range(99);
        if (r < 70) return 8'($urandom_range(8'hFF, 8'h20));
        if (r < 78) return 8'h0A;
        if (r < 83) return 8'h0D;
        if (r < 88) return 8'h08;
        if (r < 90) return 8'h0C;
        return 8'($urandom_range(31, 0));
    endfunction
    initial begin
        int busy, wa, wd;
        rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00; wipe = 1'b1;
        blank();
        mx = 0; my = 0;
        @(negedge clk);
        wipe = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ce", o_vram_ce, 0);
        chk("rst_wre", o_vram_wre, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_addr", o_vram_addr, 0);
        chk("rst_din", o_vram_din, 0);
        rst_n = 1'b1;
        check_clear();
        check_screen();
        send(8'h41, busy, wa, wd);
        chk("A_addr", wa, 'h000);
        chk("A_din", wd, 'h41);
        send(8'h42, busy, wa, wd);
        chk("B_addr", wa, 'h001);
        chk("B_din", wd, 'h42);
        chk("AB_cur_x", o_cur_x, 2);
        chk("AB_idle_addr", o_vram_addr, 'h002);
        send(8'h0D, busy, wa, wd);
        chk("cr_busy", busy, 0);
        for (int i = 0; i < COLS; i++) send(8'($urandom_range(8'h7E, 8'h20)), busy, wa, wd);
        chk("row_last_addr", wa, 'h03B);
        chk("row_wrap_cur", {o_cur_y, o_cur_x}, {5'd1, 6'd0});
        send(8'h5A, busy, wa, wd);
        chk("row_next_addr", wa, 'h040);
        send(8'h0C, busy, wa, wd);
        chk("ff_busy", busy, 1020);
        repeat (3) send(8'h0A, busy, wa, wd);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), busy, wa, wd);
        send(8'h08, busy, wa, wd);
        chk("bs_addr", wa, 'h0C4);
        chk("bs_din", wd, 'h20);
        chk("bs_cur_x", o_cur_x, 4);
        send(8'h0D, busy, wa, wd);
        send(8'h0A, busy, wa, wd);
        chk("crlf_cur", {o_cur_y, o_cur_x}, {5'd4, 6'd0});
        send(8'h08, busy, wa, wd);
        chk("bs0_busy", busy, 0);
        send(8'h0C, busy, wa, wd);
        for (int i = 0; i < COLS * ROWS - 1; i++) send(8'h80 + 8'(i % 128), busy, wa, wd);
        chk("fill_cur", {o_cur_y, o_cur_x}, {5'd16, 6'd59});
        send(8'h0A, busy, wa, wd);
        chk("scroll_cycles", busy, 2940);
        chk("scroll_cur_y", o_cur_y, 16);
        send(8'h55, busy, wa, wd);
        chk("wrap_scroll_cycles", busy, 2941);
        chk("wrap_scroll_cur", {o_cur_y, o_cur_x}, {5'd16, 6'd0});
        for (int i = 0; i < 120; i++) send(rnd_byte(), busy, wa, wd);
        for (int i = 0; i < ROWS && my < ROWS - 1; i++) send(8'h0A, busy, wa, wd);
        chk("pre_abort_cur_y", o_cur_y, 16);
        i_data = 8'h0A;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (500) @(negedge clk);
        chk("mid_scroll_ready", o_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ce", o_vram_ce, 0);
        chk("abort_ready", o_ready, 0);
        blank();
        mx = 0; my = 0;
        rst_n = 1'b1;
        check_clear();
        check_screen();
        chk("abort_cur", {o_cur_y, o_cur_x}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/term_writer.md
# term_writer

Character-stream front end that owns the upper-controller port of the 64x32 text VRAM. It accepts bytes through a valid/ready handshake, writes printable characters at the cursor cell, interprets CR/LF/BS/FF, wraps lines and hardware-scrolls the visible area by copying VRAM rows. While idle it holds the VRAM address on the cursor cell, so the text engine draws its cursor there.

## Interface
- COLS, 60: visible columns (x = 0..COLS-1, 6-bit field).
- ROWS, 17: visible rows (y = 0..ROWS-1, 5-bit field).
- i_clk  in  1  system clock (24 MHz), same clock as VRAM port A.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_data  in  8  input byte.
- i_valid  in  1  i_data valid.
- o_ready  out  1  ready to accept a byte.
- o_vram_addr  out  11  VRAM address {y[4:0], x[5:0]}.
- o_vram_din  out  8  VRAM write data.
- i_vram_dout  in  8  VRAM read data.
- o_vram_ce  out  1  VRAM clock enable.
- o_vram_wre  out  1  VRAM write (1) / read (0).
- o_cur_x  out  6  cursor column.
- o_cur_y  out  5  cursor row.

## Operation
- Byte accepted on the rising edge where i_valid & o_ready; o_ready is high only in IDLE.
- Printable (0x20–0x7E, 0x80–0xFF): write byte at {cur_y,cur_x}; cur_x+1. If cur_x reaches COLS: cur_x=0, newline.
- 0x0D CR: cur_x=0, no write.
- 0x0A LF: newline.
- 0x08 BS: if cur_x>0, cur_x-1 and write 0x20 at the new cell; at cur_x=0 no effect (no reverse wrap).
- 0x0C FF: clear screen, cursor to (0,0).
- Other codes 0x00–0x1F, 0x7F: consumed, ignored.
- Newline: if cur_y<ROWS-1, cur_y+1; else SCROLL, cur_y stays ROWS-1.
- SCROLL: for y=1..ROWS-1, x=0..COLS-1: read {y,x}, write the data to {y-1,x}; then CLRROW writes 0x20 to row ROWS-1, x=0..COLS-1.
- CLEAR: writes 0x20 to every visible cell, row-major from (0,0). Entered from reset and from FF.
- States: CLEAR, IDLE, WRITE, RD, WT, WR, CLRROW. IDLE→WRITE (printable/BS) or CLEAR (FF) or SCROLL-RD (LF at bottom, or wrap at bottom) or IDLE (CR, LF not at bottom, ignored). WRITE→IDLE, or →RD when the write wrapped past the last cell. RD→WT→WR→RD (next cell) or →CLRROW after the last cell. CLRROW→IDLE. CLEAR→IDLE.
- IDLE: o_vram_addr={cur_y,cur_x}, ce=0, wre=0.
- Cells outside COLS/ROWS (x 60–63, y 17–31) are never written.

## Timing
- Reset (i_rst_n low at an edge): state=CLEAR at sweep cell (0,0), cursor (0,0), o_ready=0, o_vram_ce=0, o_vram_wre=0, o_vram_addr=0, o_vram_din=0. Reset mid-operation aborts any sweep and restarts CLEAR.
- Printable accepted at edge T: cycle T+1 ce=1, wre=1, addr=old cursor, din=byte; T+2 IDLE with new cursor, o_ready=1. Throughput 1 byte per 2 cycles.
- CR, ignored codes, and LF not at bottom: cursor updates at T, o_ready is high again the following cycle.
- VRAM read latency 1 cycle: RD drives ce=1, wre=0, addr {y,x}; i_vram_dout valid during WT, registered at end of WT; WR drives ce=1, wre=1, addr {y-1,x}. 3 cycles per cell.
- Scroll: 3·COLS·(ROWS-1) + COLS = 2940 cycles (defaults); CLEAR: COLS·ROWS = 1020 cycles. o_ready low throughout.
- i_data is captured at acceptance; changes afterwards have no effect.

## Structure
- Package term_pkg: COLS/ROWS defaults, control codes (CR, LF, BS, FF, SPACE), state enum.
- Sub-module term_sweep: (x,y) cell counter with start row/end row, x wrap at COLS, done flag; shared by CLEAR, SCROLL and CLRROW.

## Test plan
- Reset release → 1020 consecutive writes of 0x20 covering x 0–59, y 0–16; o_ready rises at cycle 1021; addr=0.
- Write "AB" → 0x41 at addr 0x000, 0x42 at 0x001; o_cur_x=2; o_vram_addr=0x002 while idle.
- 60 printables on row 0 → last write at {0,59}; cursor (0,1); next byte written at addr 0x040.
- Cursor (5,3), send BS, CR, LF → space written at {3,4}; cursor (0,4); BS at x=0 → no write.
- Fill rows 0–16 with distinct bytes, cursor at row 16, send LF → row k now holds old row k+1, row 16 all 0x20, cursor y=16; o_ready low for exactly 2940 cycles.
- Assert i_rst_n low mid-scroll → next cycle ce=0, then full CLEAR sweep; cursor (0,0).
